// File: rtl/iccm_arb_pkg.sv
// ICCM arbiter shared types: FSM state, memory request bundle.
// Sizes here match the default ICCM geometry (4K words x 32 bits).
package iccm_arb_pkg;

  localparam int ICCM_AW = 12;
  localparam int ICCM_DW = 32;

  typedef enum logic [1:0] {
    PROG  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } arb_state_e;

  typedef struct packed {
    logic               req;
    logic               we;
    logic [ICCM_AW-1:0] addr;
    logic [ICCM_DW-1:0] wdata;
  } mem_req_t;

endpackage

// File: rtl/iccm_mem_arbiter.sv
// ICCM port owner: boot programming writes vs. core fetch reads.
// Optional ICCM_PROG_CHECKSUM_EN adds prog_csum_o / prog_wcnt_o.
module iccm_mem_arbiter
  import iccm_arb_pkg::*;
#(
  parameter int AddrW          = ICCM_AW,
  parameter int DataW          = ICCM_DW,
  parameter int MaxOutstanding = 2
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             prog_we_i,
  input  logic [AddrW-1:0] prog_addr_i,
  input  logic [DataW-1:0] prog_wdata_i,
  input  logic             prog_done_i,
  input  logic             fetch_req_i,
  input  logic [AddrW-1:0] fetch_addr_i,
  output logic             fetch_gnt_o,
  output logic [DataW-1:0] fetch_rdata_o,
  output logic             fetch_rvalid_o,
  output logic             mem_req_o,
  output logic             mem_we_o,
  output logic [AddrW-1:0] mem_addr_o,
  output logic [DataW-1:0] mem_wdata_o,
  input  logic [DataW-1:0] mem_rdata_i,
  input  logic             mem_rvalid_i,
  output logic             core_rst_no,
  output logic             prog_active_o
`ifdef ICCM_PROG_CHECKSUM_EN
  ,
  output logic [DataW-1:0] prog_csum_o,
  output logic [AddrW:0]   prog_wcnt_o
`endif
);

  localparam int CntW = $clog2(MaxOutstanding + 1);
  localparam logic [CntW-1:0] MaxCnt = CntW'(MaxOutstanding);

  arb_state_e       state_q, state_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  mem_req_t         mem_q, mem_d;
  logic             pend_v_q, pend_v_d;
  logic [AddrW-1:0] pend_addr_q, pend_addr_d;
  logic [DataW-1:0] pend_data_q, pend_data_d;
  logic             core_rst_q;
  logic             rd_tag_q;

  logic gnt;
  logic rsp_rd;
  logic drained;

  assign gnt = (state_q == RUN) && fetch_req_i
             && (cnt_q < MaxCnt) && !prog_we_i;
  assign rsp_rd  = mem_rvalid_i && rd_tag_q;
  assign drained = (state_q == DRAIN) && (cnt_q == '0);

  assign cnt_d = cnt_q + CntW'(gnt) - CntW'(rsp_rd);

  // Next state, next memory request and pending-word capture
  always_comb begin
    state_d     = state_q;
    mem_d       = '0;
    pend_v_d    = pend_v_q;
    pend_addr_d = pend_addr_q;
    pend_data_d = pend_data_q;
    unique case (state_q)
      PROG: begin
        if (prog_we_i) begin
          mem_d.req   = 1'b1;
          mem_d.we    = 1'b1;
          mem_d.addr  = prog_addr_i;
          mem_d.wdata = prog_wdata_i;
        end
        if (prog_done_i) state_d = RUN;
      end
      RUN: begin
        if (prog_we_i) begin
          pend_v_d    = 1'b1;
          pend_addr_d = prog_addr_i;
          pend_data_d = prog_wdata_i;
          state_d     = DRAIN;
        end else if (gnt) begin
          mem_d.req  = 1'b1;
          mem_d.addr = fetch_addr_i;
        end
      end
      DRAIN: begin
        if (prog_we_i) begin
          pend_v_d    = 1'b1;
          pend_addr_d = prog_addr_i;
          pend_data_d = prog_wdata_i;
        end
        if (cnt_q == '0) begin
          state_d     = PROG;
          mem_d.req   = pend_v_d;
          mem_d.we    = pend_v_d;
          mem_d.addr  = pend_addr_d;
          mem_d.wdata = pend_data_d;
          pend_v_d    = 1'b0;
        end
      end
      default: state_d = PROG;
    endcase
  end

  // State, request and response-tag registers
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= PROG;
      cnt_q       <= '0;
      mem_q       <= '0;
      pend_v_q    <= 1'b0;
      pend_addr_q <= '0;
      pend_data_q <= '0;
      core_rst_q  <= 1'b0;
      rd_tag_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      mem_q       <= mem_d;
      pend_v_q    <= pend_v_d;
      pend_addr_q <= pend_addr_d;
      pend_data_q <= pend_data_d;
      core_rst_q  <= (state_d == RUN);
      rd_tag_q    <= mem_q.req && !mem_q.we;
    end
  end

  assign fetch_gnt_o    = gnt;
  assign fetch_rvalid_o = rsp_rd;
  assign fetch_rdata_o  = rsp_rd ? mem_rdata_i : '0;
  assign mem_req_o      = mem_q.req;
  assign mem_we_o       = mem_q.we;
  assign mem_addr_o     = mem_q.addr;
  assign mem_wdata_o    = mem_q.wdata;
  assign core_rst_no    = core_rst_q;
  assign prog_active_o  = (state_q != RUN);

`ifdef ICCM_PROG_CHECKSUM_EN
  logic [DataW-1:0] csum_q;
  logic [AddrW:0]   wcnt_q;
  logic             wr_issue;

  assign wr_issue = mem_d.req && mem_d.we;

  // Running sum/count of issued writes, restarted on re-entry to PROG
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      csum_q <= '0;
      wcnt_q <= '0;
    end else if (drained || wr_issue) begin
      csum_q <= (drained ? '0 : csum_q)
              + (wr_issue ? mem_d.wdata : '0);
      wcnt_q <= (drained ? '0 : wcnt_q)
              + (AddrW+1)'(wr_issue);
    end
  end

  assign prog_csum_o = csum_q;
  assign prog_wcnt_o = wcnt_q;
`endif

  // Outstanding count stays bounded and never underflows
  always @(posedge clk_i) begin
    if (rst_ni) begin
      a_cnt_max : assert (cnt_q <= MaxCnt);
      a_cnt_uf  : assert (!(rsp_rd && !gnt && cnt_q == '0));
    end
  end

endmodule
